// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request / register-file write / hazard bundle between pipeline and arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = regfile_wb_arbiter_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_wb_arbiter_pkg::ADDR_W,
  parameter int unsigned CNT_W  = regfile_wb_arbiter_pkg::CNT_W
);

  logic              freeze;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              regWrite;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic              hazard1;
  logic              hazard2;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output freeze,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    input  writeReg, writeData, regWrite,
    output readReg1, readReg2,
    input  hazard1, hazard2,
    input  conflict_cnt
  );

  modport slave (
    input  freeze,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    output writeReg, writeData, regWrite,
    input  readReg1, readReg2,
    output hazard1, hazard2,
    output conflict_cnt
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter with enable; the last winner loses the next tie.
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_req_alu,
  input  logic i_req_mem,
  output logic o_gnt_alu,
  output logic o_gnt_mem
);

  wb_src_e r_last;
  wb_src_e w_last_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last <= WB_MEM;
    else        r_last <= w_last_nxt;
  end

  // A grant implies valid&ready, so last-grant only moves on a real transfer.
  always_comb begin
    o_gnt_alu  = 1'b0;
    o_gnt_mem  = 1'b0;
    w_last_nxt = r_last;
    if (i_en) begin
      if (i_req_alu && (!i_req_mem || (r_last == WB_MEM))) begin
        o_gnt_alu  = 1'b1;
        w_last_nxt = WB_ALU;
      end else if (i_req_mem) begin
        o_gnt_mem  = 1'b1;
        w_last_nxt = WB_MEM;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback, with a
// registered write stage, decode hazard flags and a saturating contention counter.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = regfile_wb_arbiter_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_wb_arbiter_pkg::ADDR_W,
  parameter int unsigned CNT_W  = regfile_wb_arbiter_pkg::CNT_W
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);

  import regfile_wb_arbiter_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } req_t;

  logic              w_en;
  logic              w_gnt_alu;
  logic              w_gnt_mem;
  req_t              w_sel;
  logic              w_sel_wr;
  logic              w_both;
  logic              r_regWrite;
  logic [ADDR_W-1:0] r_writeReg;
  logic [DATA_W-1:0] r_writeData;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_hz1;
  logic              w_hz2;

  assign w_en = !bus.freeze;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_en),
    .i_req_alu (bus.alu_valid),
    .i_req_mem (bus.mem_valid),
    .o_gnt_alu (w_gnt_alu),
    .o_gnt_mem (w_gnt_mem)
  );

  assign bus.alu_ready = w_gnt_alu;
  assign bus.mem_ready = w_gnt_mem;

  always_comb begin
    w_sel = '0;
    if (w_gnt_alu) begin
      w_sel.valid = 1'b1;
      w_sel.rd    = bus.alu_rd;
      w_sel.data  = bus.alu_data;
    end else if (w_gnt_mem) begin
      w_sel.valid = 1'b1;
      w_sel.rd    = bus.mem_rd;
      w_sel.data  = bus.mem_data;
    end
  end

  // x0 transfers are still accepted; they just never reach the register file.
  assign w_sel_wr = w_sel.valid && (w_sel.rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regWrite  <= 1'b0;
      r_writeReg  <= '0;
      r_writeData <= '0;
    end else begin
      r_regWrite <= w_sel_wr;
      if (w_sel_wr) begin
        r_writeReg  <= w_sel.rd;
        r_writeData <= w_sel.data;
      end
    end
  end

  assign bus.regWrite  = r_regWrite;
  assign bus.writeReg  = r_writeReg;
  assign bus.writeData = r_writeData;

  assign w_both = bus.alu_valid && bus.mem_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (w_both && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.conflict_cnt = r_cnt;

  // Register file has no bypass, so the write stage counts as in flight.
  always_comb begin
    w_hz1 = 1'b0;
    w_hz2 = 1'b0;
    if (bus.readReg1 != '0) begin
      w_hz1 = (bus.alu_valid && (bus.alu_rd == bus.readReg1)) ||
              (bus.mem_valid && (bus.mem_rd == bus.readReg1)) ||
              (r_regWrite && (r_writeReg == bus.readReg1));
    end
    if (bus.readReg2 != '0) begin
      w_hz2 = (bus.alu_valid && (bus.alu_rd == bus.readReg2)) ||
              (bus.mem_valid && (bus.mem_rd == bus.readReg2)) ||
              (r_regWrite && (r_writeReg == bus.readReg2));
    end
  end

  assign bus.hazard1 = w_hz1;
  assign bus.hazard2 = w_hz2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: per-cycle vector table plus reset/freeze sequences.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_err;
  int   n_chk;

  regfile_wb_arbiter_if #(.DATA_W(64), .ADDR_W(5), .CNT_W(16)) bus ();

  regfile_wb_arbiter #(.DATA_W(64), .ADDR_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        frz;
    wb_req_t     alu;
    wb_req_t     mem;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic        e_ar;
    logic        e_mr;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [63:0] e_wd;
    logic        e_h1;
    logic        e_h2;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int unsigned NV = 19;
  vec_t vt [NV];

  function automatic vec_t mk(
    input logic frz,
    input logic av, input logic [4:0] ard, input logic [63:0] ad,
    input logic mv, input logic [4:0] mrd, input logic [63:0] md,
    input logic [4:0] rr1, input logic [4:0] rr2,
    input logic ear, input logic emr, input logic erw,
    input logic [4:0] ewr, input logic [63:0] ewd,
    input logic eh1, input logic eh2, input logic [15:0] ecnt);
    vec_t v;
    v.frz   = frz;
    v.alu   = '{valid: av, rd: ard, data: ad};
    v.mem   = '{valid: mv, rd: mrd, data: md};
    v.rr1   = rr1;
    v.rr2   = rr2;
    v.e_ar  = ear;
    v.e_mr  = emr;
    v.e_rw  = erw;
    v.e_wr  = ewr;
    v.e_wd  = ewd;
    v.e_h1  = eh1;
    v.e_h2  = eh2;
    v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic frz, input wb_req_t a, input wb_req_t m,
                       input logic [4:0] rr1, input logic [4:0] rr2);
    bus.freeze    = frz;
    bus.alu_valid = a.valid;
    bus.alu_rd    = a.rd;
    bus.alu_data  = a.data;
    bus.mem_valid = m.valid;
    bus.mem_rd    = m.rd;
    bus.mem_data  = m.data;
    bus.readReg1  = rr1;
    bus.readReg2  = rr2;
  endtask

  wb_req_t idle_r;

  initial begin
    n_err  = 0;
    n_chk  = 0;
    idle_r = '0;

    // Each row is one cycle; register expectations reflect the previous row's transfer.
    //            frz av ard  ad            mv mrd md      rr1 rr2 ar mr rw wr  wd            h1 h2 cnt
    vt[0]  = mk(0, 1, 5,  64'hDEADBEEF,  0, 0,  0,      5,  0,  1, 0, 0, 0,  64'h0,        1, 0, 0);
    vt[1]  = mk(0, 0, 0,  0,             0, 0,  0,      5,  6,  0, 0, 1, 5,  64'hDEADBEEF, 1, 0, 0);
    vt[2]  = mk(0, 0, 0,  0,             1, 0,  'h1234, 0,  5,  0, 1, 0, 5,  64'hDEADBEEF, 0, 0, 0);
    vt[3]  = mk(0, 0, 0,  0,             0, 0,  0,      0,  0,  0, 0, 0, 5,  64'hDEADBEEF, 0, 0, 0);
    vt[4]  = mk(0, 1, 1,  'hA1,          1, 11, 'hB11,  11, 1,  1, 0, 0, 5,  64'hDEADBEEF, 1, 1, 0);
    vt[5]  = mk(0, 1, 2,  'hA2,          1, 11, 'hB11,  1,  2,  0, 1, 1, 1,  64'hA1,       1, 1, 1);
    vt[6]  = mk(0, 1, 2,  'hA2,          1, 12, 'hB12,  11, 3,  1, 0, 1, 11, 64'hB11,      1, 0, 2);
    vt[7]  = mk(0, 1, 3,  'hA3,          1, 12, 'hB12,  12, 0,  0, 1, 1, 2,  64'hA2,       1, 0, 3);
    vt[8]  = mk(0, 1, 3,  'hA3,          0, 0,  0,      12, 2,  1, 0, 1, 12, 64'hB12,      1, 0, 4);
    vt[9]  = mk(0, 0, 0,  0,             1, 7,  'h77,   7,  8,  0, 1, 1, 3,  64'hA3,       1, 0, 4);
    vt[10] = mk(0, 0, 0,  0,             0, 0,  0,      7,  8,  0, 0, 1, 7,  64'h77,       1, 0, 4);
    vt[11] = mk(0, 0, 0,  0,             0, 0,  0,      7,  3,  0, 0, 0, 7,  64'h77,       0, 0, 4);
    vt[12] = mk(0, 1, 9,  'h99,          0, 0,  0,      9,  0,  1, 0, 0, 7,  64'h77,       1, 0, 4);
    vt[13] = mk(1, 1, 10, 'h1010,        0, 0,  0,      9,  10, 0, 0, 1, 9,  64'h99,       1, 1, 4);
    vt[14] = mk(1, 1, 10, 'h1010,        0, 0,  0,      9,  10, 0, 0, 0, 9,  64'h99,       0, 1, 4);
    vt[15] = mk(0, 1, 10, 'h1010,        0, 0,  0,      0,  10, 1, 0, 0, 9,  64'h99,       0, 1, 4);
    vt[16] = mk(0, 0, 0,  0,             0, 0,  0,      10, 0,  0, 0, 1, 10, 64'h1010,     1, 0, 4);
    vt[17] = mk(1, 1, 3,  'h33,          1, 4,  'h44,   3,  4,  0, 0, 0, 10, 64'h1010,     1, 1, 4);
    vt[18] = mk(0, 0, 0,  0,             0, 0,  0,      3,  4,  0, 0, 0, 10, 64'h1010,     0, 0, 5);

    // Reset with both sources requesting.
    rst_n = 1'b0;
    drive(1'b0, '{valid: 1'b1, rd: 5'd3, data: 64'h3}, '{valid: 1'b1, rd: 5'd4, data: 64'h4}, 5'd0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst regWrite", {63'd0, bus.regWrite}, 64'd0);
    chk("rst writeReg", {59'd0, bus.writeReg}, 64'd0);
    chk("rst writeData", bus.writeData, 64'd0);
    chk("rst conflict_cnt", {48'd0, bus.conflict_cnt}, 64'd0);
    chk("rst mem_ready", {63'd0, bus.mem_ready}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post-rst alu_ready", {63'd0, bus.alu_ready}, 64'd1);
    chk("post-rst mem_ready", {63'd0, bus.mem_ready}, 64'd0);
    drive(1'b0, idle_r, idle_r, 5'd0, 5'd0);

    for (int unsigned i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(vt[i].frz, vt[i].alu, vt[i].mem, vt[i].rr1, vt[i].rr2);
      #1;
      chk($sformatf("v%0d alu_ready", i), {63'd0, bus.alu_ready}, {63'd0, vt[i].e_ar});
      chk($sformatf("v%0d mem_ready", i), {63'd0, bus.mem_ready}, {63'd0, vt[i].e_mr});
      chk($sformatf("v%0d regWrite", i), {63'd0, bus.regWrite}, {63'd0, vt[i].e_rw});
      chk($sformatf("v%0d writeReg", i), {59'd0, bus.writeReg}, {59'd0, vt[i].e_wr});
      chk($sformatf("v%0d writeData", i), bus.writeData, vt[i].e_wd);
      chk($sformatf("v%0d hazard1", i), {63'd0, bus.hazard1}, {63'd0, vt[i].e_h1});
      chk($sformatf("v%0d hazard2", i), {63'd0, bus.hazard2}, {63'd0, vt[i].e_h2});
      chk($sformatf("v%0d conflict_cnt", i), {48'd0, bus.conflict_cnt}, {48'd0, vt[i].e_cnt});
    end

    // Reset one cycle after an ALU grant: pending write dropped, last_grant back to MEM.
    @(posedge clk);
    #1;
    drive(1'b0, '{valid: 1'b1, rd: 5'd20, data: 64'h2020}, idle_r, 5'd0, 5'd0);
    #1;
    chk("mid-rst grant alu_ready", {63'd0, bus.alu_ready}, 64'd1);
    @(posedge clk);
    #1;
    drive(1'b0, idle_r, idle_r, 5'd0, 5'd0);
    #1;
    chk("mid-rst stage regWrite", {63'd0, bus.regWrite}, 64'd1);
    chk("mid-rst stage writeReg", {59'd0, bus.writeReg}, 64'd20);
    rst_n = 1'b0;
    #1;
    chk("mid-rst async regWrite", {63'd0, bus.regWrite}, 64'd0);
    chk("mid-rst async writeReg", {59'd0, bus.writeReg}, 64'd0);
    chk("mid-rst async writeData", bus.writeData, 64'd0);
    chk("mid-rst async conflict_cnt", {48'd0, bus.conflict_cnt}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, '{valid: 1'b1, rd: 5'd21, data: 64'h21}, '{valid: 1'b1, rd: 5'd22, data: 64'h22}, 5'd0, 5'd0);
    #1;
    chk("after-rst alu_ready", {63'd0, bus.alu_ready}, 64'd1);
    chk("after-rst mem_ready", {63'd0, bus.mem_ready}, 64'd0);
    chk("after-rst regWrite", {63'd0, bus.regWrite}, 64'd0);
    drive(1'b0, idle_r, idle_r, 5'd0, 5'd0);
    for (int unsigned k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("after-rst idle%0d regWrite", k), {63'd0, bus.regWrite}, 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
